// File: rtl/cpu_ctrl_pkg.sv
// Shared state, opcode/funct and select encodings for the multi-cycle control path.
package cpu_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, HALT
  } state_t;

  // ALU operation class requested by the current state
  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  } aluOp_t;

  localparam logic [OPCODE_W-1:0] OP_R    = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h08;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SEL_W-1:0] SRCB_REGB    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_ctl_decode.sv
// Maps the state's ALU class plus the R-type funct field to an aluCtl code.
// functIllegal is reported independently of the class so DECODE can use it.
module alu_ctl_decode
  import cpu_ctrl_pkg::*;
(
  input  aluOp_t              aluOp,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] aluCtl,
  output logic                functIllegal
);

  logic [ALUCTL_W-1:0] functCtl;

  always_comb begin
    functCtl     = ALU_ADD;
    functIllegal = 1'b0;
    case (funct)
      FN_ADD:  functCtl = ALU_ADD;
      FN_SUB:  functCtl = ALU_SUB;
      FN_AND:  functCtl = ALU_AND;
      FN_OR:   functCtl = ALU_OR;
      FN_SLT:  functCtl = ALU_SLT;
      default: functIllegal = 1'b1;
    endcase
  end

  always_comb begin
    aluCtl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB:   aluCtl = ALU_SUB;
      ALUOP_FUNCT: aluCtl = functCtl;
      default:     aluCtl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences the datapath one state per clock and
// counts retired instructions. Outputs are Moore decodes of state, gated by run.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W      = 32,
  parameter bit          ILLEGAL_TRAP = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                regWriteEnable,
  output logic                iorD,
  output logic                regDst,
  output logic                memToReg,
  output logic                aluSrcA,
  output logic [SEL_W-1:0]    aluSrcB,
  output logic [ALUCTL_W-1:0] aluCtl,
  output logic [SEL_W-1:0]    pcSource,
  output logic                illegal,
  output logic                halted,
  output logic [COUNT_W-1:0]  instrCount
);

  state_t state;
  state_t stateNext;
  aluOp_t aluOp;
  logic   functIllegal;
  logic   retire;
  logic   pcWriteRaw, irWriteRaw, memReadRaw, memWriteRaw, regWriteRaw;
  logic   illegalRaw, haltedRaw;
  logic   strobeEn;

  alu_ctl_decode uAluCtl (
    .aluOp        (aluOp),
    .funct        (funct),
    .aluCtl       (aluCtl),
    .functIllegal (functIllegal)
  );

  always_ff @(posedge clock) begin
    if (reset)    state <= FETCH;
    else if (run) state <= stateNext;
  end

  always_ff @(posedge clock) begin
    if (reset)              instrCount <= '0;
    else if (run && retire) instrCount <= instrCount + COUNT_W'(1);
  end

  always_comb begin
    stateNext   = state;
    aluOp       = ALUOP_ADD;
    retire      = 1'b0;
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    memReadRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    haltedRaw   = 1'b0;
    iorD        = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REGB;
    pcSource    = PCSRC_ALU;
    case (state)
      FETCH: begin
        memReadRaw = 1'b1;
        irWriteRaw = 1'b1;
        pcWriteRaw = 1'b1;
        aluSrcB    = SRCB_FOUR;
        stateNext  = DECODE;
      end
      DECODE: begin
        // branch target is precomputed into ALUOut while the opcode is decoded
        aluSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: stateNext = MEM_ADDR;
          OP_R:         stateNext = R_EXEC;
          OP_BEQ:       stateNext = BRANCH;
          OP_J:         stateNext = JUMP;
          OP_ADDI:      stateNext = I_EXEC;
          default:      illegalRaw = 1'b1;
        endcase
        if (opcode == OP_R && functIllegal) illegalRaw = 1'b1;
        if (illegalRaw) stateNext = ILLEGAL_TRAP ? HALT : FETCH;
      end
      MEM_ADDR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        stateNext = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        memReadRaw = 1'b1;
        iorD       = 1'b1;
        stateNext  = MEM_WB;
      end
      MEM_WB: begin
        regWriteRaw = 1'b1;
        memToReg    = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end
      MEM_WRITE: begin
        memWriteRaw = 1'b1;
        iorD        = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end
      R_EXEC: begin
        aluSrcA   = 1'b1;
        aluOp     = ALUOP_FUNCT;
        stateNext = R_WB;
      end
      R_WB: begin
        regWriteRaw = 1'b1;
        regDst      = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end
      I_EXEC: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        stateNext = I_WB;
      end
      I_WB: begin
        regWriteRaw = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        aluOp      = ALUOP_SUB;
        pcSource   = PCSRC_ALUOUT;
        pcWriteRaw = zero;
        retire     = 1'b1;
        stateNext  = FETCH;
      end
      JUMP: begin
        pcSource   = PCSRC_JUMP;
        pcWriteRaw = 1'b1;
        retire     = 1'b1;
        stateNext  = FETCH;
      end
      HALT: begin
        haltedRaw = 1'b1;
        stateNext = HALT;
      end
      default: stateNext = FETCH;
    endcase
  end

  // strobes only fire while running and out of reset
  assign strobeEn       = run & ~reset;
  assign pcWrite        = strobeEn & pcWriteRaw;
  assign irWrite        = strobeEn & irWriteRaw;
  assign memRead        = strobeEn & memReadRaw;
  assign memWrite       = strobeEn & memWriteRaw;
  assign regWriteEnable = strobeEn & regWriteRaw;
  assign illegal        = strobeEn & illegalRaw;
  assign halted         = ~reset & haltedRaw;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors (value + care
// mask) for each instruction class, plus run-hold, reset-abort, trap and wrap.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        reset, run, zero;
  logic [5:0]  opcode, funct;
  logic        pcWrite, irWrite, memRead, memWrite, regWriteEnable, iorD, regDst, memToReg, aluSrcA;
  logic [1:0]  aluSrcB, pcSource;
  logic [2:0]  aluCtl;
  logic        illegal, halted;
  logic [31:0] instrCount;
  logic        tPcWrite, tIrWrite, tMemRead, tMemWrite, tRegWriteEnable, tIorD, tRegDst, tMemToReg, tAluSrcA;
  logic [1:0]  tAluSrcB, tPcSource;
  logic [2:0]  tAluCtl;
  logic        tIllegal, tHalted;
  logic [3:0]  tInstrCount;

  int          nTests = 0;
  int          nFail = 0;
  logic [31:0] expCount = 32'd0;

  multicycle_control #(.COUNT_W(32), .ILLEGAL_TRAP(1'b0)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
    .regWriteEnable(regWriteEnable), .iorD(iorD), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluCtl(aluCtl), .pcSource(pcSource),
    .illegal(illegal), .halted(halted), .instrCount(instrCount)
  );

  multicycle_control #(.COUNT_W(4), .ILLEGAL_TRAP(1'b1)) dutTrap (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
    .pcWrite(tPcWrite), .irWrite(tIrWrite), .memRead(tMemRead), .memWrite(tMemWrite),
    .regWriteEnable(tRegWriteEnable), .iorD(tIorD), .regDst(tRegDst), .memToReg(tMemToReg),
    .aluSrcA(tAluSrcA), .aluSrcB(tAluSrcB), .aluCtl(tAluCtl), .pcSource(tPcSource),
    .illegal(tIllegal), .halted(tHalted), .instrCount(tInstrCount)
  );

  always #5 clock = ~clock;

  // Vector layout: {pcWrite,irWrite,memRead,memWrite,regWriteEnable,illegal,halted,
  //                 iorD,regDst,memToReg, aluSrcA, aluSrcB[2], aluCtl[3], pcSource[2]}
  // Each entry is {care[17:0], value[17:0]}.
  localparam logic [35:0] E_FETCH  = {{7'h7F, 3'b100, 1'b1, 2'b11, 3'b111, 2'b11},
                                      {7'b1110000, 3'b000, 1'b0, 2'b01, 3'b010, 2'b00}};
  localparam logic [35:0] E_DECODE = {{7'h7F, 3'b000, 1'b0, 2'b11, 3'b111, 2'b00},
                                      {7'b0000000, 3'b000, 1'b0, 2'b11, 3'b010, 2'b00}};
  localparam logic [35:0] E_DECILL = {{7'h7F, 3'b000, 1'b0, 2'b11, 3'b111, 2'b00},
                                      {7'b0000010, 3'b000, 1'b0, 2'b11, 3'b010, 2'b00}};
  localparam logic [35:0] E_MADDR  = {{7'h7F, 3'b000, 1'b1, 2'b11, 3'b111, 2'b00},
                                      {7'b0000000, 3'b000, 1'b1, 2'b10, 3'b010, 2'b00}};
  localparam logic [35:0] E_MREAD  = {{7'h7F, 3'b100, 8'h00}, {7'b0010000, 3'b100, 8'h00}};
  localparam logic [35:0] E_MWB    = {{7'h7F, 3'b011, 8'h00}, {7'b0000100, 3'b001, 8'h00}};
  localparam logic [35:0] E_MWRITE = {{7'h7F, 3'b100, 8'h00}, {7'b0001000, 3'b100, 8'h00}};
  localparam logic [35:0] E_RWB    = {{7'h7F, 3'b011, 8'h00}, {7'b0000100, 3'b010, 8'h00}};
  localparam logic [35:0] E_IWB    = {{7'h7F, 3'b011, 8'h00}, {7'b0000100, 3'b000, 8'h00}};
  localparam logic [35:0] E_JUMP   = {{7'h7F, 3'b000, 1'b0, 2'b00, 3'b000, 2'b11},
                                      {7'b1000000, 3'b000, 1'b0, 2'b00, 3'b000, 2'b10}};
  localparam logic [35:0] E_HALT   = {{7'h7F, 11'h000}, {7'b0000001, 11'h000}};
  localparam logic [35:0] E_IDLE   = {{7'b1111100, 11'h000}, 18'h00000};

  function automatic logic [35:0] rExec(input logic [2:0] ctl);
    return {{7'h7F, 3'b000, 1'b1, 2'b11, 3'b111, 2'b00},
            {7'b0000000, 3'b000, 1'b1, 2'b00, ctl, 2'b00}};
  endfunction

  function automatic logic [35:0] branch(input logic z);
    return {{7'h7F, 3'b000, 1'b1, 2'b11, 3'b111, 2'b11},
            {z, 6'b000000, 3'b000, 1'b1, 2'b00, 3'b110, 2'b01}};
  endfunction

  function automatic logic [17:0] packMain();
    return {pcWrite, irWrite, memRead, memWrite, regWriteEnable, illegal, halted,
            iorD, regDst, memToReg, aluSrcA, aluSrcB, aluCtl, pcSource};
  endfunction

  function automatic logic [17:0] packTrap();
    return {tPcWrite, tIrWrite, tMemRead, tMemWrite, tRegWriteEnable, tIllegal, tHalted,
            tIorD, tRegDst, tMemToReg, tAluSrcA, tAluSrcB, tAluCtl, tPcSource};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    reset = 1'b1; run = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h20;
    tick();
    #1;
    obs = packMain();
    nTests++;
    if (((obs ^ E_IDLE[17:0]) & E_IDLE[35:18]) !== 18'h0) begin
      nFail++; $display("FAIL reset_strobes: got %h want %h care %h", obs, E_IDLE[17:0], E_IDLE[35:18]);
    end
    tick();
    reset = 1'b0;
    #1;
    obs = packMain();
    nTests++;
    if (((obs ^ E_FETCH[17:0]) & E_FETCH[35:18]) !== 18'h0) begin
      nFail++; $display("FAIL reset_fetch: got %h want %h care %h", obs, E_FETCH[17:0], E_FETCH[35:18]);
    end
    nTests++;
    if (instrCount !== 32'd0 || tInstrCount !== 4'd0) begin
      nFail++; $display("FAIL reset_count: got %0d/%0d want 0/0", instrCount, tInstrCount);
    end
  endtask

  task automatic test_add();
    logic [35:0] seq [4];
    logic [17:0] obs;
    seq = '{E_FETCH, E_DECODE, rExec(3'b010), E_RWB};
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      obs = packMain();
      nTests++;
      if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
        nFail++; $display("FAIL add cyc%0d: got %h want %h care %h", i + 1, obs, seq[i][17:0], seq[i][35:18]);
      end
      tick();
    end
    expCount = 32'd1;
    nTests++;
    if (instrCount !== expCount) begin
      nFail++; $display("FAIL add_count: got %0d want %0d", instrCount, expCount);
    end
  endtask

  task automatic test_r_funct();
    logic [5:0]  fns [4];
    logic [2:0]  ctls [4];
    logic [35:0] seq [4];
    logic [17:0] obs;
    fns  = '{6'h22, 6'h24, 6'h25, 6'h2A};
    ctls = '{3'b110, 3'b000, 3'b001, 3'b111};
    opcode = 6'h00;
    for (int k = 0; k < 4; k++) begin
      funct = fns[k];
      seq = '{E_FETCH, E_DECODE, rExec(ctls[k]), E_RWB};
      for (int i = 0; i < 4; i++) begin
        #1;
        obs = packMain();
        nTests++;
        if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
          nFail++; $display("FAIL rfunct_%h cyc%0d: got %h want %h care %h", fns[k], i + 1, obs, seq[i][17:0], seq[i][35:18]);
        end
        tick();
      end
    end
    expCount = expCount + 32'd4;
    nTests++;
    if (instrCount !== expCount) begin
      nFail++; $display("FAIL rfunct_count: got %0d want %0d", instrCount, expCount);
    end
  endtask

  task automatic test_lw_sw();
    logic [35:0] seq [9];
    logic [17:0] obs;
    seq = '{E_FETCH, E_DECODE, E_MADDR, E_MREAD, E_MWB, E_FETCH, E_DECODE, E_MADDR, E_MWRITE};
    opcode = 6'h23; funct = 6'h00;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) opcode = 6'h2B;
      #1;
      obs = packMain();
      nTests++;
      if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
        nFail++; $display("FAIL lw_sw cyc%0d: got %h want %h care %h", i + 1, obs, seq[i][17:0], seq[i][35:18]);
      end
      tick();
    end
    expCount = expCount + 32'd2;
    nTests++;
    if (instrCount !== expCount) begin
      nFail++; $display("FAIL lw_sw_count: got %0d want %0d", instrCount, expCount);
    end
  endtask

  task automatic test_beq();
    logic [35:0] seq [6];
    logic [17:0] obs;
    seq = '{E_FETCH, E_DECODE, branch(1'b1), E_FETCH, E_DECODE, branch(1'b0)};
    opcode = 6'h04; zero = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) zero = 1'b0;
      #1;
      obs = packMain();
      nTests++;
      if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
        nFail++; $display("FAIL beq cyc%0d: got %h want %h care %h", i + 1, obs, seq[i][17:0], seq[i][35:18]);
      end
      tick();
    end
    expCount = expCount + 32'd2;
    nTests++;
    if (instrCount !== expCount) begin
      nFail++; $display("FAIL beq_count: got %0d want %0d", instrCount, expCount);
    end
  endtask

  task automatic test_j_addi();
    logic [35:0] seq [7];
    logic [17:0] obs;
    seq = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH, E_DECODE, E_MADDR, E_IWB};
    opcode = 6'h02;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) opcode = 6'h08;
      #1;
      obs = packMain();
      nTests++;
      if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
        nFail++; $display("FAIL j_addi cyc%0d: got %h want %h care %h", i + 1, obs, seq[i][17:0], seq[i][35:18]);
      end
      tick();
    end
    expCount = expCount + 32'd2;
    nTests++;
    if (instrCount !== expCount) begin
      nFail++; $display("FAIL j_addi_count: got %0d want %0d", instrCount, expCount);
    end
  endtask

  task automatic test_wrap();
    opcode = 6'h02;
    for (int i = 0; i < 12; i++) tick();
    expCount = expCount + 32'd4;
    nTests++;
    if (tInstrCount !== 4'hF || instrCount !== 32'd15) begin
      nFail++; $display("FAIL wrap_top: got %0d/%0d want 15/15", tInstrCount, instrCount);
    end
    for (int i = 0; i < 3; i++) tick();
    expCount = expCount + 32'd1;
    nTests++;
    if (tInstrCount !== 4'h0 || instrCount !== expCount) begin
      nFail++; $display("FAIL wrap_roll: got %0d/%0d want 0/%0d", tInstrCount, instrCount, expCount);
    end
  endtask

  task automatic test_illegal();
    logic [35:0] seq [4];
    logic [17:0] obs;
    seq = '{E_FETCH, E_DECILL, E_FETCH, E_DECILL};
    opcode = 6'h3F; funct = 6'h20;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin opcode = 6'h00; funct = 6'h3F; end
      #1;
      obs = packMain();
      nTests++;
      if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
        nFail++; $display("FAIL illegal cyc%0d: got %h want %h care %h", i + 1, obs, seq[i][17:0], seq[i][35:18]);
      end
      if (i == 1) begin
        nTests++;
        if (tIllegal !== 1'b1) begin
          nFail++; $display("FAIL trap_pulse: got %b want 1", tIllegal);
        end
      end
      tick();
    end
    obs = packMain();
    nTests++;
    if (((obs ^ E_FETCH[17:0]) & E_FETCH[35:18]) !== 18'h0 || instrCount !== expCount) begin
      nFail++; $display("FAIL illegal_back: got %h cnt %0d want %h cnt %0d", obs, instrCount, E_FETCH[17:0], expCount);
    end
    obs = packTrap();
    nTests++;
    if (((obs ^ E_HALT[17:0]) & E_HALT[35:18]) !== 18'h0 || tInstrCount !== 4'h0) begin
      nFail++; $display("FAIL trap_halt: got %h cnt %0d want %h cnt 0", obs, tInstrCount, E_HALT[17:0]);
    end
  endtask

  task automatic test_run_hold();
    logic [35:0] seq [10];
    logic        runTab [10];
    logic [17:0] obs;
    seq = '{E_FETCH, E_DECODE, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_IDLE, rExec(3'b010), E_IDLE, E_RWB};
    runTab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 10; i++) begin
      run = runTab[i];
      #1;
      obs = packMain();
      nTests++;
      if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
        nFail++; $display("FAIL run_hold cyc%0d: got %h want %h care %h", i + 1, obs, seq[i][17:0], seq[i][35:18]);
      end
      if (i == 8) begin
        nTests++;
        if (instrCount !== expCount) begin
          nFail++; $display("FAIL hold_count: got %0d want %0d", instrCount, expCount);
        end
      end
      tick();
    end
    expCount = expCount + 32'd1;
    nTests++;
    if (instrCount !== expCount) begin
      nFail++; $display("FAIL resume_count: got %0d want %0d", instrCount, expCount);
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] seq [5];
    logic        rstTab [5];
    logic [17:0] obs;
    seq = '{E_FETCH, E_DECODE, E_MADDR, E_IDLE, E_FETCH};
    rstTab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'h23; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reset = rstTab[i];
      #1;
      obs = packMain();
      nTests++;
      if (((obs ^ seq[i][17:0]) & seq[i][35:18]) !== 18'h0) begin
        nFail++; $display("FAIL reset_mid cyc%0d: got %h want %h care %h", i + 1, obs, seq[i][17:0], seq[i][35:18]);
      end
      if (i == 4) begin
        expCount = 32'd0;
        nTests++;
        if (instrCount !== expCount || tInstrCount !== 4'h0 || tHalted !== 1'b0) begin
          nFail++; $display("FAIL reset_mid_state: got cnt %0d/%0d halted %b want 0/0 halted 0", instrCount, tInstrCount, tHalted);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_r_funct();
    test_lw_sw();
    test_beq();
    test_j_addi();
    test_wrap();
    test_illegal();
    test_run_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
